// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the dual-issue instruction-fetch controller.
// Revision: 1.0
`default_nettype none

package if_fetch_ctrl_pkg;

  localparam int          ADDR_W       = 32;
  localparam int          INST_W       = 64;
  localparam logic [31:0] RESET_PC     = 32'hbfc0_0000;
  localparam logic [31:0] FETCH_STRIDE = 32'd8;
  localparam logic [63:0] NOP_PAIR     = 64'h0;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2,
    S_ERR   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_pair_t;

  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/response port: req/gnt handshake, rvalid-qualified read data.
// Revision: 1.0
`default_nettype none

interface if_fetch_ctrl_if;
  import if_fetch_ctrl_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

`default_nettype wire

// File: rtl/if_skid_buf.sv
// One-entry {instruction pair, pc} holding buffer used while the decode stage stalls.
// Revision: 1.0
`default_nettype none

module if_skid_buf
  import if_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_pair_t din,
  output fetch_pair_t dout,
  output logic        full
);

  fetch_pair_t data;

  // A push in the same cycle as a pop replaces the entry and keeps it full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      data <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  assign dout = data;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the single-outstanding I-memory handshake
// and delivers PC-tagged instruction pairs to IF/ID, dropping responses made stale by redirects.
`default_nettype none

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = if_fetch_ctrl_pkg::RESET_PC,
  parameter logic [31:0] FETCH_STRIDE = if_fetch_ctrl_pkg::FETCH_STRIDE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   exc_req,
  input  logic [31:0]            exc_pc,
  input  logic                   br_req,
  input  logic [31:0]            br_target,
  input  logic                   stall,
  if_fetch_ctrl_if.master        imem,
  output logic                   if_valid,
  output logic [63:0]            if_inst,
  output logic [31:0]            if_pc,
  output logic                   if_adel
);
  import if_fetch_ctrl_pkg::*;

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx, req_pc;
  logic [31:0]  redir_pc;
  logic         redirect, req_ok, hs;
  logic         rvalid_live, deliver_new, adel_emit;
  logic         skid_push, skid_pop, skid_full;
  fetch_pair_t  skid_in, skid_out;

  assign redirect = exc_req | br_req;
  assign redir_pc = exc_req ? exc_pc : br_target;

  assign req_ok    = (state == S_REQ) && !stall && !skid_full && !misaligned(pc);
  assign imem.req  = req_ok & ~reset;
  assign imem.addr = pc;
  assign hs        = imem.req & imem.gnt;

  // Only a response to the live request in WAIT is usable; anything else is stale or stray.
  assign rvalid_live = imem.rvalid && (state == S_WAIT) && !redirect;
  assign deliver_new = rvalid_live && !stall && !skid_full;
  assign skid_push   = rvalid_live && (stall || skid_full);
  assign skid_pop    = skid_full && !stall;
  assign adel_emit   = (state == S_REQ) && misaligned(pc) && !redirect && !stall && !skid_full;

  assign skid_in = '{inst: imem.rdata, pc: req_pc};

  if_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (redirect),
    .din   (skid_in),
    .dout  (skid_out),
    .full  (skid_full)
  );

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if (redirect) begin
      pc_nx = redir_pc;
    end else if (hs) begin
      pc_nx = pc + FETCH_STRIDE;
    end
    case (state)
      S_REQ: begin
        if (hs) begin
          state_nx = redirect ? S_FLUSH : S_WAIT;
        end else if (adel_emit) begin
          state_nx = S_ERR;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          state_nx = imem.rvalid ? S_REQ : S_FLUSH;
        end else if (imem.rvalid) begin
          state_nx = S_REQ;
        end
      end
      S_FLUSH: begin
        if (imem.rvalid) begin
          state_nx = S_REQ;
        end
      end
      S_ERR: begin
        if (redirect) begin
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (hs) begin
        req_pc <= pc;
      end
    end
  end

  // Buffered data outranks fresh data; stall freezes the IF/ID outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_inst  <= NOP_PAIR;
      if_pc    <= 32'h0;
      if_adel  <= 1'b0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_adel  <= 1'b0;
    end else if (!stall) begin
      if (skid_full) begin
        if_valid <= 1'b1;
        if_inst  <= skid_out.inst;
        if_pc    <= skid_out.pc;
        if_adel  <= 1'b0;
      end else if (deliver_new) begin
        if_valid <= 1'b1;
        if_inst  <= imem.rdata;
        if_pc    <= req_pc;
        if_adel  <= 1'b0;
      end else if (adel_emit) begin
        if_valid <= 1'b1;
        if_inst  <= NOP_PAIR;
        if_pc    <= pc;
        if_adel  <= 1'b1;
      end else begin
        if_valid <= 1'b0;
        if_adel  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: memory responder, delivery scoreboard, next-PC vector table.
`default_nettype none

module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_req = 1'b0, br_req = 1'b0, stall = 1'b0;
  logic [31:0] exc_pc = 32'h0, br_target = 32'h0;
  logic        if_valid, if_adel;
  logic [63:0] if_inst;
  logic [31:0] if_pc;

  if_fetch_ctrl_if imem();

  if_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .exc_req   (exc_req),
    .exc_pc    (exc_pc),
    .br_req    (br_req),
    .br_target (br_target),
    .stall     (stall),
    .imem      (imem),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc),
    .if_adel   (if_adel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] pc; logic [63:0] inst; logic adel; } exp_t;
  exp_t        expq[$];
  exp_t        got;
  logic [31:0] gnt_log[$];

  typedef struct {
    logic exc, br, stl;
    logic [31:0] epc, tgt;
    logic ereq;
    logic [31:0] eaddr;
    logic evalid;
  } vec_t;
  vec_t vt[7];

  // memory model state
  logic        gnt_en = 1'b0;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'h5a5a_0000, a ^ 32'h0000_a5a5};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic adel);
    exp_t e;
    e.pc   = pc;
    e.inst = adel ? 64'h0 : mem_word(pc);
    e.adel = adel;
    expq.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
    chk(name, 64'(expq.size()), 64'd0);
  endtask

  // I-memory responder: grants when enabled, answers after 'lat' cycles.
  initial begin
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 64'h0;
    forever begin
      @(negedge clk); #1;
      imem.rvalid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem.rvalid = 1'b1;
          imem.rdata  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem.gnt = gnt_en;
      if (imem.req && imem.gnt && !pend) begin
        pend = 1'b1; pend_addr = imem.addr; cnt = lat - 1;
        gnt_log.push_back(imem.addr);
      end
    end
  end

  // Scoreboard: every unstalled if_valid cycle is one delivery.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!reset && if_valid && !stall) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_delivery: got pc %h expected none", if_pc);
        end else begin
          got = expq.pop_front();
          chk("deliver_pc", 64'(if_pc), 64'(got.pc));
          chk("deliver_inst", if_inst, got.inst);
          chk("deliver_adel", 64'(if_adel), 64'(got.adel));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'hbfc0_0018, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h8000_0180, 32'h0,         1'b1, 32'h8000_0180, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h8000_0100, 1'b1, 32'h8000_0100, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h8000_0180, 32'h8000_0100, 1'b1, 32'h8000_0180, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h8000_0200, 1'b0, 32'h8000_0200, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0, 32'h8000_0200, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h8000_0000, 1'b0};

    // reset values
    gnt_en = 1'b1; lat = 1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req", 64'(imem.req), 64'd0);
    chk("rst_addr", 64'(imem.addr), 64'hbfc0_0000);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_inst", if_inst, 64'd0);
    chk("rst_pc", 64'(if_pc), 64'd0);
    chk("rst_adel", 64'(if_adel), 64'd0);

    // sequential fetch, gnt always 1, rvalid one cycle after gnt
    push_exp(32'hbfc0_0000, 1'b0);
    push_exp(32'hbfc0_0008, 1'b0);
    push_exp(32'hbfc0_0010, 1'b0);
    @(negedge clk); reset = 1'b0;
    #2;
    chk("first_req", 64'(imem.req), 64'd1);
    @(negedge clk);
    @(negedge clk); #2;
    chk("lag_valid", 64'(if_valid), 64'd1);
    chk("lag_pc", 64'(if_pc), 64'hbfc0_0000);
    for (int i = 0; i < 30 && gnt_log.size() < 3; i++) @(negedge clk);
    gnt_en = 1'b0;
    wait_drain("seq_drain");
    chk("seq_addr0", 64'(gnt_log[0]), 64'hbfc0_0000);
    chk("seq_addr1", 64'(gnt_log[1]), 64'hbfc0_0008);
    chk("seq_addr2", 64'(gnt_log[2]), 64'hbfc0_0010);

    // next-PC priority table, no grants
    for (int i = 0; i < 7; i++) begin
      exc_req = vt[i].exc; br_req = vt[i].br; stall = vt[i].stl;
      exc_pc = vt[i].epc; br_target = vt[i].tgt;
      @(negedge clk);
      exc_req = 1'b0; br_req = 1'b0;
      #2;
      chk($sformatf("vec%0d_req", i), 64'(imem.req), 64'(vt[i].ereq));
      chk($sformatf("vec%0d_addr", i), 64'(imem.addr), 64'(vt[i].eaddr));
      chk($sformatf("vec%0d_valid", i), 64'(if_valid), 64'(vt[i].evalid));
    end

    // branch while WAIT: stale response dropped
    @(negedge clk); lat = 2; gnt_en = 1'b1;
    @(negedge clk); gnt_en = 1'b0; br_req = 1'b1; br_target = 32'h8000_0100;
    @(negedge clk); br_req = 1'b0;
    @(negedge clk); lat = 1; gnt_en = 1'b1; push_exp(32'h8000_0100, 1'b0);
    #2;
    chk("flush_valid", 64'(if_valid), 64'd0);
    chk("flush_req", 64'(imem.req), 64'd1);
    chk("flush_addr", 64'(imem.addr), 64'h8000_0100);
    @(negedge clk); gnt_en = 1'b0;
    wait_drain("br_drain");

    // redirect coincident with grant: granted request is stale
    gnt_en = 1'b1; br_req = 1'b1; br_target = 32'h8000_0300;
    @(negedge clk); gnt_en = 1'b0; br_req = 1'b0;
    @(negedge clk); #2;
    chk("gntredir_req", 64'(imem.req), 64'd1);
    chk("gntredir_addr", 64'(imem.addr), 64'h8000_0300);
    chk("gntredir_valid", 64'(if_valid), 64'd0);

    // stall for three cycles with the response landing in the skid buffer
    @(negedge clk); lat = 2; gnt_en = 1'b1;
    @(negedge clk); gnt_en = 1'b0; stall = 1'b1;
    @(negedge clk);
    @(negedge clk); #2;
    chk("stall_req", 64'(imem.req), 64'd0);
    chk("stall_valid_hold", 64'(if_valid), 64'd0);
    chk("stall_pc_hold", 64'(if_pc), 64'h8000_0100);
    @(negedge clk); stall = 1'b0;
    push_exp(32'h8000_0300, 1'b0);
    push_exp(32'h8000_0308, 1'b0);
    #2;
    chk("skid_full_req", 64'(imem.req), 64'd0);
    @(negedge clk); lat = 1; gnt_en = 1'b1;
    #2;
    chk("skid_out_valid", 64'(if_valid), 64'd1);
    chk("skid_out_pc", 64'(if_pc), 64'h8000_0300);
    @(negedge clk); gnt_en = 1'b0;
    wait_drain("stall_drain");

    // misaligned branch target
    @(negedge clk); br_req = 1'b1; br_target = 32'h8000_0102;
    @(negedge clk); br_req = 1'b0; push_exp(32'h8000_0102, 1'b1);
    #2;
    chk("adel_noreq", 64'(imem.req), 64'd0);
    @(negedge clk); #2;
    chk("adel_flag", 64'(if_adel), 64'd1);
    chk("adel_pc", 64'(if_pc), 64'h8000_0102);
    @(negedge clk); #2;
    chk("err_valid", 64'(if_valid), 64'd0);
    chk("err_req", 64'(imem.req), 64'd0);
    @(negedge clk); exc_req = 1'b1; exc_pc = 32'h8000_0180;
    @(negedge clk); exc_req = 1'b0;
    #2;
    chk("err_recover_req", 64'(imem.req), 64'd1);
    chk("err_recover_addr", 64'(imem.addr), 64'h8000_0180);

    // reset pulse while WAIT, stray response afterwards
    @(negedge clk); lat = 3; gnt_en = 1'b1;
    @(negedge clk); gnt_en = 1'b0; reset = 1'b1;
    #2;
    chk("midrst_req", 64'(imem.req), 64'd0);
    chk("midrst_addr", 64'(imem.addr), 64'hbfc0_0000);
    chk("midrst_valid", 64'(if_valid), 64'd0);
    chk("midrst_pc", 64'(if_pc), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); #2;
    chk("stray_valid", 64'(if_valid), 64'd0);
    chk("stray_addr", 64'(imem.addr), 64'hbfc0_0000);
    @(negedge clk); #2;
    chk("stray_valid2", 64'(if_valid), 64'd0);

    chk("final_queue", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
